cfi_shadow_monitor: RTL

Parametrised control-flow-integrity monitor on the commit stage: per-cycle inspection of every acknowledged commit port, with a hardware shadow return stack and an indirect-call landing-pad check. Armed by a software enable marker; once armed, a return to an address other than the one pushed at the matching call, or an indirect call not landing on a landing-pad marker, raises a sticky violation and a halt request to the commit stage. Sits beside `commit_stage`, fed from the same `commit_instr` / `commit_ack` signals.

---
 rtl/cfi_pkg.sv | 54 +++++
 rtl/cfi_shadow_stack.sv | 81 ++++++++
 rtl/cfi_shadow_monitor.sv | 137 +++++++++++++
 3 files changed

// File: rtl/cfi_pkg.sv
// Shared types for the CFI shadow monitor: a trimmed commit-entry view of the core,
// state/cause/expectation encodings and the instruction classifier.
package cfi_pkg;
  localparam int unsigned VLEN            = 32;
  localparam int unsigned NR_COMMIT_PORTS = 2;

  typedef enum logic [3:0] {FU_NONE, LOAD, STORE, ALU, CTRL_FLOW, MULT, CSR} fu_t;
  typedef enum logic [6:0] {ADD, SUB, ANDL, ORL, XORL, JAL, JALR, EQ, NE} fu_op;

  typedef struct packed {
    logic [VLEN-1:0] pc;
    fu_t             fu;
    fu_op            op;
    logic [4:0]      rs1;
    logic [4:0]      rd;
    logic [VLEN-1:0] result;
  } scoreboard_entry_t;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'd0,
    RET_MISMATCH = 2'd1,
    LPAD_MISSING = 2'd2,
    SS_UNDERFLOW = 2'd3
  } cfi_cause_e;

  typedef enum logic [1:0] {CFI_DISABLED, CFI_ARMED, CFI_VIOLATED} cfi_state_e;
  typedef enum logic [1:0] {EXP_NONE, EXP_RET, EXP_LPAD} cfi_exp_e;

  localparam logic [1:0] MARK_ENABLE = 2'b10;
  localparam logic [1:0] MARK_LPAD   = 2'b11;
  localparam logic [4:0] REG_X0      = 5'd0;
  localparam logic [4:0] REG_X1      = 5'd1;

  typedef struct packed {
    logic enable;
    logic lpad;
    logic call;
    logic icall;
    logic ret;
  } cfi_class_t;

  function automatic cfi_class_t classify(scoreboard_entry_t e);
    cfi_class_t c;
    logic       marker;
    // Markers are "add x0, x1, imm" encodings whose low result bits carry the tag
    marker  = (e.fu == ALU) && (e.op == ADD) && (e.rs1 == REG_X1) && (e.rd == REG_X0);
    c.enable = marker && (e.result[1:0] == MARK_ENABLE);
    c.lpad   = marker && (e.result[1:0] == MARK_LPAD);
    c.call   = (e.fu == CTRL_FLOW) && ((e.op == JAL) || (e.op == JALR)) && (e.rd == REG_X1);
    c.icall  = c.call && (e.op == JALR);
    c.ret    = (e.fu == CTRL_FLOW) && (e.op == JALR) && (e.rs1 == REG_X1) && (e.rd == REG_X0);
    return c;
  endfunction
endpackage

// File: rtl/cfi_shadow_stack.sv
// Circular shadow return stack. Per-port push/pop requests are resolved in port order;
// top_o/empty_o show the stack as each port sees it, and only the first apply_n_i ops commit.
module cfi_shadow_stack import cfi_pkg::*; #(
  parameter  int unsigned NrPorts = 2,
  parameter  int unsigned SsDepth = 8,
  localparam int unsigned PW      = $clog2(SsDepth),
  localparam int unsigned CW      = $clog2(SsDepth) + 1,
  localparam int unsigned AW      = $clog2(NrPorts + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           flush_i,
  input  logic [NrPorts-1:0]             push_i,
  input  logic [NrPorts-1:0]             pop_i,
  input  logic [NrPorts-1:0][VLEN-1:0]   data_i,
  input  logic [AW-1:0]                  apply_n_i,
  output logic [NrPorts-1:0][VLEN-1:0]   top_o,
  output logic [NrPorts-1:0]             empty_o,
  output logic [CW-1:0]                  count_o
);
  logic [SsDepth-1:0][VLEN-1:0] mem_q, mem_d;
  logic [PW-1:0]                head_q, head_d;
  logic [CW-1:0]                count_q, count_d;

  always_comb begin
    logic [SsDepth-1:0][VLEN-1:0] m;
    logic [PW-1:0]                h;
    logic [CW-1:0]                c;
    m       = mem_q;
    h       = head_q;
    c       = count_q;
    mem_d   = mem_q;
    head_d  = head_q;
    count_d = count_q;
    top_o   = '0;
    empty_o = '0;
    for (int p = 0; p < NrPorts; p++) begin
      // Views ignore apply_n_i so nothing here depends on the checks that consume them
      if (AW'(p) == apply_n_i) begin
        mem_d   = m;
        head_d  = h;
        count_d = c;
      end
      top_o[p]   = m[h - PW'(1)];
      empty_o[p] = (c == '0);
      if (push_i[p]) begin
        m[h] = data_i[p];
        h    = h + PW'(1);
        if (c != CW'(SsDepth)) c = c + CW'(1);
      end else if (pop_i[p] && (c != '0)) begin
        h = h - PW'(1);
        c = c - CW'(1);
      end
    end
    if (apply_n_i == AW'(NrPorts)) begin
      mem_d   = m;
      head_d  = h;
      count_d = c;
    end
    if (flush_i) begin
      head_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign count_o = count_q;
endmodule

// File: rtl/cfi_shadow_monitor.sv
// Control-flow-integrity monitor beside the commit stage: shadow return stack plus
// landing-pad check, armed by a software marker, raising a sticky halt on violation.
module cfi_shadow_monitor import cfi_pkg::*; #(
  parameter  int unsigned NrPorts = NR_COMMIT_PORTS,
  parameter  int unsigned SsDepth = 8,
  parameter  bit          LpadEn  = 1'b1,
  localparam int unsigned CW      = $clog2(SsDepth) + 1,
  localparam int unsigned AW      = $clog2(NrPorts + 1)
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  scoreboard_entry_t [NrPorts-1:0]     commit_instr_i,
  input  logic [NrPorts-1:0]                  commit_ack_i,
  input  logic                                ex_valid_i,
  input  logic                                clear_i,
  output logic                                enabled_o,
  output logic                                violation_o,
  output logic                                halt_o,
  output logic [1:0]                          cause_o,
  output logic [VLEN-1:0]                     viol_pc_o,
  output logic [CW-1:0]                       ss_count_o
);
  cfi_state_e                   state_q, state_d;
  cfi_exp_e                     pend_q, pend_d;
  logic [VLEN-1:0]              pend_addr_q, pend_addr_d;
  cfi_cause_e                   cause_q, cause_d;
  logic [VLEN-1:0]              vpc_q, vpc_d;
  cfi_class_t                   cls [NrPorts];
  logic [NrPorts-1:0]           push, pop, empty_v;
  logic [NrPorts-1:0][VLEN-1:0] push_data, top_v;
  logic [AW-1:0]                apply_n;
  logic                         flush;

  always_comb begin
    for (int p = 0; p < NrPorts; p++) begin
      cls[p]       = classify(commit_instr_i[p]);
      push[p]      = commit_ack_i[p] && cls[p].call;
      pop[p]       = commit_ack_i[p] && cls[p].ret;
      push_data[p] = commit_instr_i[p].result;
    end
  end

  cfi_shadow_stack #(.NrPorts(NrPorts), .SsDepth(SsDepth)) i_stack (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .flush_i   (flush),
    .push_i    (push),
    .pop_i     (pop),
    .data_i    (push_data),
    .apply_n_i (apply_n),
    .top_o     (top_v),
    .empty_o   (empty_v),
    .count_o   (ss_count_o)
  );

  always_comb begin
    cfi_cause_e bad;
    logic       stop;
    state_d     = state_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    cause_d     = cause_q;
    vpc_d       = vpc_q;
    apply_n     = '0;
    flush       = 1'b0;
    stop        = 1'b0;
    bad         = CAUSE_NONE;
    unique case (state_q)
      CFI_DISABLED: begin
        for (int p = 0; p < NrPorts; p++)
          if (commit_ack_i[p] && cls[p].enable) state_d = CFI_ARMED;
      end
      CFI_ARMED: begin
        apply_n = AW'(NrPorts);
        for (int p = 0; p < NrPorts; p++) begin
          if (commit_ack_i[p] && !stop) begin
            bad = CAUSE_NONE;
            if (pend_d == EXP_RET && commit_instr_i[p].pc != pend_addr_d) bad = RET_MISMATCH;
            else if (pend_d == EXP_LPAD && !cls[p].lpad)                  bad = LPAD_MISSING;
            pend_d = EXP_NONE;
            if (bad == CAUSE_NONE && cls[p].ret) begin
              if (empty_v[p]) bad = SS_UNDERFLOW;
              else begin
                pend_d      = EXP_RET;
                pend_addr_d = top_v[p];
              end
            end
            if (bad == CAUSE_NONE && cls[p].icall && LpadEn) pend_d = EXP_LPAD;
            // First offender wins; its own stack op and every later port are dropped
            if (bad != CAUSE_NONE) begin
              stop    = 1'b1;
              apply_n = AW'(p);
              cause_d = bad;
              vpc_d   = commit_instr_i[p].pc;
              state_d = CFI_VIOLATED;
            end
          end
        end
        if (ex_valid_i) pend_d = EXP_NONE;
      end
      CFI_VIOLATED: ;
      default: state_d = CFI_DISABLED;
    endcase
    if (clear_i && state_q != CFI_DISABLED) begin
      state_d = CFI_ARMED;
      pend_d  = EXP_NONE;
      flush   = 1'b1;
      cause_d = cause_q;
      vpc_d   = vpc_q;
    end
  end

  // Commit-edge register stage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= CFI_DISABLED;
      pend_q  <= EXP_NONE;
      cause_q <= CAUSE_NONE;
      vpc_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cause_q <= cause_d;
      vpc_q   <= vpc_d;
    end
  end

  always_ff @(posedge clk_i) begin
    pend_addr_q <= pend_addr_d;
  end

  assign enabled_o   = (state_q != CFI_DISABLED);
  assign violation_o = (state_q == CFI_VIOLATED);
  assign halt_o      = violation_o;
  assign cause_o     = cause_q;
  assign viol_pc_o   = vpc_q;
endmodule
